// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver with internal baud counter.
//
// Recovers frames of 1 start bit, 8 data bits (LSB first) and 1 stop bit from
// the asynchronous rx line. A good frame updates po_data and pulses po_flag
// for one sclk cycle. A frame whose stop bit samples low pulses frame_err and
// leaves po_data untouched.
//
// Parameters:
//   CLK_FREQ  sclk frequency in Hz
//   BAUD      line bit rate; CLK_FREQ/BAUD must be >= 8
//
// Ports:
//   sclk       in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   rx         in   asynchronous serial line, idle high
//   po_data    out  [7:0] last validly received byte
//   po_flag    out  one-cycle strobe, po_data updated this cycle
//   frame_err  out  one-cycle strobe, stop bit low and byte discarded
//   rx_busy    out  high while a frame is being received
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, each bit decision is a 2-of-3 vote of
//                        rx_s at BAUD_HALF-1, BAUD_HALF and BAUD_HALF+1, taken
//                        at BAUD_HALF+1 (po_flag one sclk later than default).
//                        When undefined, a single sample at BAUD_HALF is used.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD;
  localparam int BAUD_HALF    = BAUD_CNT_MAX / 2;
  localparam int CW           = $clog2(BAUD_CNT_MAX);

  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_VOTE0 = CW'(BAUD_HALF - 1);
  localparam logic [CW-1:0] CNT_VOTE1 = CW'(BAUD_HALF);
  localparam logic [CW-1:0] CNT_DECIDE = CW'(BAUD_HALF + 1);
`else
  localparam logic [CW-1:0] CNT_DECIDE = CW'(BAUD_HALF);
`endif

  if (BAUD_CNT_MAX < 8) begin : g_bad_baud
    $error("uart_rx: CLK_FREQ/BAUD must be at least 8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    po_data_q, po_data_d;
  logic          po_flag_q, po_flag_d;
  logic          frame_err_q, frame_err_d;

  // Two flops resynchronise rx; the third delays rx_s for edge detection.
  // All three reset high so releasing reset never looks like a start edge.
  logic rx_m_q, rx_s_q, rx_d_q;
  logic fall;

  logic baud_wrap;
  logic sample_hit;
  logic sample_bit;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop capture the previous
      // stage's old value, forming a real 3-stage pipeline.
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
      rx_d_q <= rx_s_q;
    end
  end

  assign fall      = rx_d_q & ~rx_s_q;
  assign baud_wrap = (baud_cnt_q == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
  // The first two votes are held here; the third is rx_s at the decision tick.
  logic vote0_q, vote1_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      vote0_q <= 1'b1;
      vote1_q <= 1'b1;
    end else begin
      if (baud_cnt_q == CNT_VOTE0) vote0_q <= rx_s_q;
      if (baud_cnt_q == CNT_VOTE1) vote1_q <= rx_s_q;
    end
  end

  assign sample_hit = (baud_cnt_q == CNT_DECIDE);
  assign sample_bit = (vote0_q & vote1_q) | (vote0_q & rx_s_q) | (vote1_q & rx_s_q);
`else
  assign sample_hit = (baud_cnt_q == CNT_DECIDE);
  assign sample_bit = rx_s_q;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    po_data_d   = po_data_q;
    po_flag_d   = 1'b0;
    frame_err_d = 1'b0;

    if (state_q == IDLE) begin
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      if (fall) state_d = START;
    end else begin
      baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + CW'(1);
      unique case (state_q)
        START: begin
          if (sample_hit && sample_bit) begin
            // Line went back high by mid start bit: treat as a glitch.
            state_d    = IDLE;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
          end else if (baud_wrap) begin
            state_d   = DATA;
            bit_cnt_d = 4'd1;
          end
        end
        DATA: begin
          if (sample_hit) shift_d = {sample_bit, shift_q[7:1]};
          if (baud_wrap) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd8) state_d = STOP;
          end
        end
        STOP: begin
          // Leave half a bit early so a back-to-back start edge is seen.
          if (sample_hit) begin
            state_d    = IDLE;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            if (sample_bit) begin
              po_data_d = shift_q;
              po_flag_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      po_data_q   <= '0;
      po_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      po_data_q   <= po_data_d;
      po_flag_q   <= po_flag_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign po_data   = po_data_q;
  assign po_flag   = po_flag_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at 16 sclk per bit.
// Expected strobes are queued when a frame is driven and retired by a monitor
// whenever the receiver raises po_flag or frame_err.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CLK_FREQ   = 50_000_000;
  localparam int BAUD       = 3_125_000;
  localparam int BIT        = 16;
  localparam int GLITCH_OFF = 9;  // lands on rx_s at the BAUD_HALF sample
`ifdef UART_RX_MAJORITY_EN
  localparam int         LAT        = 157;
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam int         LAT        = 156;
  localparam logic [7:0] GLITCH_EXP = 8'h04;
`endif

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       sclk  = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;
  logic       rx_busy;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] last_data   = 8'h00;
  logic       prev_strobe = 1'b0;
  int         cyc         = 0;
  int         t_start     = 0;
  int         flag_cyc    = 0;
  int         flag_cnt    = 0;
  int         err_cnt     = 0;
  int         n_total     = 0;
  int         n_bad       = 0;
  int         f0, e0;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .rx       (rx),
    .po_data  (po_data),
    .po_flag  (po_flag),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #10 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Strobe monitor: sampled 1 time unit after each rising edge.
  always @(posedge sclk) begin
    #1;
    if (po_flag || frame_err) begin
      check("flag_err_exclusive", {31'b0, po_flag & frame_err}, 0);
      check("strobe_one_cycle", {31'b0, prev_strobe}, 0);
      if (po_flag) begin
        flag_cnt++;
        flag_cyc = cyc;
      end
      if (frame_err) err_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_kind", {31'b0, frame_err}, {31'b0, mon_e.is_err});
        if (mon_e.is_err) begin
          check("po_data_hold", {24'b0, po_data}, {24'b0, last_data});
        end else begin
          check("po_data", {24'b0, po_data}, {24'b0, mon_e.data});
          last_data = mon_e.data;
        end
      end
    end
    prev_strobe = po_flag | frame_err;
  end

  // Drives one bit for BIT clocks; called and returns at a falling edge.
  task automatic drive_bit(input logic b, input logic glitch);
    for (int i = 0; i < BIT; i++) begin
      rx = (glitch && i == GLITCH_OFF) ? ~b : b;
      @(negedge sclk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int glitch_bit);
    t_start = cyc;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], glitch_bit == i);
    drive_bit(stop_b, 1'b0);
    rx = 1'b1;
  endtask

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge sclk);
    check("rst_po_data", {24'b0, po_data}, 0);
    check("rst_po_flag", {31'b0, po_flag}, 0);
    check("rst_frame_err", {31'b0, frame_err}, 0);
    check("rst_rx_busy", {31'b0, rx_busy}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge sclk);

    // Single good frame.
    f0 = flag_cnt; e0 = err_cnt;
    sb.push_back('{is_err: 1'b0, data: 8'h55});
    send_frame(8'h55, 1'b1, -1);
    check("t1_busy_after_stop", {31'b0, rx_busy}, 0);
    check("t1_latency", flag_cyc - t_start, LAT);
    repeat (5) @(negedge sclk);
    check("t1_flag_count", flag_cnt - f0, 1);
    check("t1_err_count", err_cnt - e0, 0);

    // Back-to-back frames, next start right at the end of the stop bit.
    f0 = flag_cnt;
    sb.push_back('{is_err: 1'b0, data: 8'hA3});
    sb.push_back('{is_err: 1'b0, data: 8'h0F});
    send_frame(8'hA3, 1'b1, -1);
    send_frame(8'h0F, 1'b1, -1);
    repeat (10) @(negedge sclk);
    check("t2_flag_count", flag_cnt - f0, 2);
    check("t2_po_data", {24'b0, po_data}, 32'h0F);

    // Short low pulse from idle: start aborted at the sample point.
    f0 = flag_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (3) @(negedge sclk);
    check("t3_busy_during", {31'b0, rx_busy}, 1);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge sclk);
    check("t3_busy_after", {31'b0, rx_busy}, 0);
    check("t3_flag_count", flag_cnt - f0, 0);
    check("t3_err_count", err_cnt - e0, 0);

    // Stop bit low: frame error, data held.
    f0 = flag_cnt; e0 = err_cnt;
    sb.push_back('{is_err: 1'b1, data: 8'h0F});
    send_frame(8'h3C, 1'b0, -1);
    repeat (10) @(negedge sclk);
    check("t4_err_count", err_cnt - e0, 1);
    check("t4_flag_count", flag_cnt - f0, 0);
    check("t4_po_data", {24'b0, po_data}, 32'h0F);

    // Reset during data bit 4 of 0xFF, then a clean frame.
    f0 = flag_cnt; e0 = err_cnt;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    rx = 1'b1;
    repeat (5) @(negedge sclk);
    rst_n = 1'b0;
    repeat (2) @(negedge sclk);
    check("t5_rst_po_data", {24'b0, po_data}, 0);
    check("t5_rst_busy", {31'b0, rx_busy}, 0);
    last_data = 8'h00;
    rst_n = 1'b1;
    repeat (6 * BIT) @(negedge sclk);
    check("t5_no_strobe", (flag_cnt - f0) + (err_cnt - e0), 0);
    sb.push_back('{is_err: 1'b0, data: 8'h81});
    send_frame(8'h81, 1'b1, -1);
    repeat (10) @(negedge sclk);
    check("t5_flag_count", flag_cnt - f0, 1);
    check("t5_po_data", {24'b0, po_data}, 32'h81);

    // One-sclk inverted glitch mid data bit 2 of 0x00.
    sb.push_back('{is_err: 1'b0, data: GLITCH_EXP});
    send_frame(8'h00, 1'b1, 2);
    repeat (10) @(negedge sclk);
    check("t6_po_data", {24'b0, po_data}, {24'b0, GLITCH_EXP});

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive stage. Sits directly upstream of the UART transmit stage.
- Samples the asynchronous `rx` line and recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop).
- On each valid frame, presents the byte on `po_data` with a single-cycle `po_flag` strobe, which drives the transmitter's `po_data`/`po_flag` inputs directly.
- Contains its own baud counter; no external bit-timing inputs.

Parameters:
- CLK_FREQ, 50_000_000, sclk frequency in Hz.
- BAUD, 9600, line bit rate. Derived localparam BAUD_CNT_MAX = CLK_FREQ/BAUD (integer divide); BAUD_HALF = BAUD_CNT_MAX/2. BAUD_CNT_MAX must be >= 8.

Ports:
- sclk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  asynchronous serial line, idle high.
- po_data  output  8  last validly received byte.
- po_flag  output  1  one-cycle strobe: po_data updated this cycle.
- frame_err  output  1  one-cycle strobe: stop bit sampled low, byte discarded.
- rx_busy  output  1  high while a frame is being received.

Behaviour:
- Clock and reset: one clock (sclk). Reset is asynchronous and active-low (rst_n).
- Reset values: po_data=8'h00, po_flag=0, frame_err=0, rx_busy=0, state=IDLE, counters=0. The three rx synchroniser/edge flops reset to 1, so there is no false edge on release.
- Synchronisation: rx passes through 2 flops to give rx_s. A third flop gives rx_d. fall = rx_d & ~rx_s.
- baud_cnt (width clog2(BAUD_CNT_MAX)):
  - Cleared to 0 in IDLE.
  - Counts 0..BAUD_CNT_MAX-1 and wraps while rx_busy.
  - Sample point: baud_cnt==BAUD_HALF.
- bit_cnt (4 bits): 0=start, 1..8=data, 9=stop. Increments on each baud_cnt wrap.
- States:
  - IDLE: rx_busy=0. On fall, go to START. baud_cnt=0, bit_cnt=0, rx_busy=1 next cycle.
  - START: at the sample point, if rx_s==1 (glitch) go to IDLE with no outputs. Otherwise continue; at wrap go to DATA with bit_cnt=1.
  - DATA: at the sample point, shift rx_s into shift_reg[7] and right-shift, so the LSB arrives first. At the wrap after bit_cnt==8 go to STOP.
  - STOP: at the sample point, go to IDLE immediately (half bit early, so a back-to-back start edge is caught).
    - rx_s==1: po_data<=shift_reg, po_flag=1 for exactly one cycle.
    - rx_s==0: frame_err=1 for one cycle; po_data unchanged.
- Latency: po_flag rises 1 sclk after the stop-bit sample point, which is about 9.5 bit times plus 3 sclk after the start falling edge.
- po_data holds its value between frames. po_flag and frame_err are never high together.
- Falling edges during START/DATA/STOP are ignored (no restart).
- rx held low permanently: the frame ends in frame_err. IDLE is then re-entered with rx_s low, so no fall occurs and no new frame starts until rx returns high and falls again.
- Reset asserted mid-frame: all state clears asynchronously. The partial byte is discarded and no strobe is emitted.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each start, data and stop decision uses a 2-of-3 majority of rx_s sampled at baud_cnt==BAUD_HALF-1, BAUD_HALF and BAUD_HALF+1. The decision and its actions take effect at BAUD_HALF+1. po_flag latency grows by 1 sclk.
- Undefined: single sample at BAUD_HALF, as above.

Test Plan (CLK_FREQ=50_000_000, BAUD=3_125_000 so BAUD_CNT_MAX=16; unless stated, benches run with UART_RX_MAJORITY_EN undefined):
- Frame 0x55, stop high -> one po_flag pulse, po_data=8'h55, frame_err stays 0, rx_busy low after the stop sample.
- Frames 0xA3 then 0x0F back-to-back, start edge right at the end of the stop bit -> two po_flag pulses, po_data=8'hA3 then 8'h0F.
- rx low for 3 sclk from idle -> START aborts at the sample point; no po_flag, no frame_err, rx_busy returns to 0.
- Frame 0x3C with stop bit driven low -> frame_err pulse for 1 cycle, no po_flag, po_data keeps its previous value.
- rst_n pulsed low during data bit 4 of frame 0xFF, then a clean 0x81 frame -> no strobe for the aborted frame, po_data=8'h00 after reset, then po_data=8'h81.
- UART_RX_MAJORITY_EN defined: 1-sclk inverted glitch at BAUD_HALF of data bit 2 in frame 0x00 -> po_data=8'h00. With the macro undefined, the same stimulus gives po_data=8'h04.
